hazard_forward_unit: RTL

- Parametrised successor to the pipeline's combinational forwarding logic.
- Keeps its own registered history of in-flight destination registers, FWD_DEPTH entries deep, and generates per-operand forwarding selects for the EX stage.
- Adds load-use stall generation, with a configurable load latency, and branch-taken flush control.
- Sits beside the IF/ID/EX/MEM/WB pipeline registers and drives their stall, flush and bubble controls and the EX operand muxes.

---
 rtl/hazard_forward_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard/forward unit: dest-register history, EX forwarding selects,
// load-use stall FSM and branch-taken flush for the 5-stage pipeline.
//
// Ports:
//   CLK, RST_n               clock, synchronous active-low reset
//   opcode_id, rs1/rs2_id    instruction in ID (load-use detection)
//   opcode_ex, rs1/rs2_ex    instruction in EX (operand forwarding)
//   rd_ex, reg_write_ex      EX producer, pushed into the history
//   mem_read_ex              EX instruction is a load
//   branch_taken_ex          branch/jump in EX resolved taken
//   forwardA/B               0 = regfile, k = history entry k-1
//   stall_pc, stall_if_id    hold PC and IF/ID
//   bubble_id_ex             load a NOP into ID/EX
//   flush_if_id, flush_id_ex squash IF/ID and ID/EX
module hazard_forward_unit #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int SELW      = $clog2(FWD_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [6:0]        opcode_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [6:0]        opcode_ex,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              branch_taken_ex,
    output logic [SELW-1:0]   forwardA,
    output logic [SELW-1:0]   forwardB,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex
);

    localparam int CNTW = $clog2(LOAD_LAT + 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LD, OP_S, OP_B, OP_JALR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_B: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // Producer history: entry 0 is MEM, entry 1 is WB, and so on.
    logic [FWD_DEPTH-1:0] h_valid;
    logic [FWD_DEPTH-1:0] h_we;
    logic [REG_AW-1:0]    h_rd [FWD_DEPTH];

    // Stages past EX never stall, so the shift runs every cycle.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            h_valid <= '0;
            h_we    <= '0;
            for (int i = 0; i < FWD_DEPTH; i++) begin
                h_rd[i] <= '0;
            end
        end else begin
            h_valid[0] <= 1'b1;
            h_we[0]    <= reg_write_ex;
            h_rd[0]    <= rd_ex;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                h_valid[i] <= h_valid[i-1];
                h_we[i]    <= h_we[i-1];
                h_rd[i]    <= h_rd[i-1];
            end
        end
    end

    logic use1_ex;
    logic use2_ex;

    assign use1_ex = uses_rs1(opcode_ex);
    assign use2_ex = uses_rs2(opcode_ex);

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        forwardA = '0;
        forwardB = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (h_valid[k-1] && h_we[k-1] && (h_rd[k-1] != '0)) begin
                if (use1_ex && (h_rd[k-1] == rs1_ex)) begin
                    forwardA = SELW'(k);
                end
                if (use2_ex && (h_rd[k-1] == rs2_ex)) begin
                    forwardB = SELW'(k);
                end
            end
        end
    end

    logic hz;
    logic flush;

    assign hz = mem_read_ex && (rd_ex != '0) &&
                ((uses_rs1(opcode_id) && (rd_ex == rs1_id)) ||
                 (uses_rs2(opcode_id) && (rd_ex == rs2_id)));

    assign flush = branch_taken_ex;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            stall;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first bubble is issued from IDLE while the load is still in
    // EX; STALL supplies the remaining LOAD_LAT-1 bubbles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz && !flush) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = STALL;
                        cnt_d   = CNTW'(LOAD_LAT - 1);
                    end
                end
            end
            STALL: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_pc     = stall;
    assign stall_if_id  = stall;
    assign bubble_id_ex = stall;
    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;

endmodule
